// File: rtl/chunk_stream_source.sv
// Host-side responder for the chunk-streaming handshake: serves key, nonce and counter
// words from host-loaded storage, one chunk_valid pulse per request episode.
module chunk_stream_source #(
    parameter int AUTO_INC   = 1,
    parameter int RESP_DELAY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             chunk_request,
    input  logic [1:0]       request_type,
    input  logic [4:0]       chunk_index,
    output logic             chunk_valid,
    output logic [1:0]       chunk_type,
    output logic [31:0]      chunk,
    output logic             busy,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] served_count
);

    typedef enum logic [1:0] {IDLE, DELAY, COOL} state_t;

    localparam logic [3:0] DLY = 4'(RESP_DELAY);
    localparam logic [1:0] T_KEY = 2'd0, T_NONCE = 2'd1, T_CNT = 2'd2;

    state_t      state;
    logic [3:0]  dly;
    logic [1:0]  cap_type;
    logic [4:0]  cap_idx;

    logic [31:0] key [8];
    logic [31:0] nonce [3];
    logic [31:0] counter;

    logic        serve_now;
    logic [1:0]  serve_type;
    logic [4:0]  serve_idx;
    logic        req_legal;

    function automatic logic is_legal(input logic [1:0] t, input logic [4:0] idx);
        case (t)
            T_KEY:   is_legal = (idx < 5'd8);
            T_NONCE: is_legal = (idx < 5'd3);
            T_CNT:   is_legal = (idx == 5'd0);
            default: is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_word(input logic [1:0] t, input logic [4:0] idx);
        read_word = 32'd0;
        case (t)
            T_KEY: read_word = key[idx[2:0]];
            T_NONCE: begin
                case (idx[1:0])
                    2'd0:    read_word = nonce[0];
                    2'd1:    read_word = nonce[1];
                    2'd2:    read_word = nonce[2];
                    default: read_word = 32'd0;
                endcase
            end
            T_CNT:   read_word = counter;
            default: read_word = 32'd0;
        endcase
    endfunction

    // The serve decision is shared by the FSM and the counter auto-increment.
    always_comb begin
        req_legal  = is_legal(request_type, chunk_index);
        serve_type = cap_type;
        serve_idx  = cap_idx;
        serve_now  = 1'b0;
        if (state == IDLE) begin
            serve_type = request_type;
            serve_idx  = chunk_index;
            serve_now  = chunk_request && req_legal && (RESP_DELAY == 0);
        end else if (state == DELAY) begin
            serve_now  = (dly == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) key[i] <= 32'd0;
            for (int i = 0; i < 3; i++) nonce[i] <= 32'd0;
            counter <= 32'd0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    4'd0, 4'd1, 4'd2, 4'd3,
                    4'd4, 4'd5, 4'd6, 4'd7: key[cfg_addr[2:0]] <= cfg_wdata;
                    4'd8:    nonce[0] <= cfg_wdata;
                    4'd9:    nonce[1] <= cfg_wdata;
                    4'd10:   nonce[2] <= cfg_wdata;
                    default: ;
                endcase
            end
            // A host write to the counter wins over the increment at the same edge.
            if (cfg_we && cfg_addr == 4'd11)
                counter <= cfg_wdata;
            else if (AUTO_INC != 0 && serve_now && serve_type == T_CNT)
                counter <= counter + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dly          <= 4'd0;
            cap_type     <= 2'd0;
            cap_idx      <= 5'd0;
            chunk_valid  <= 1'b0;
            chunk_type   <= 2'd0;
            chunk        <= 32'd0;
            busy         <= 1'b0;
            err          <= 1'b0;
            served_count <= '0;
        end else begin
            chunk_valid <= 1'b0;
            if (err_clr) err <= 1'b0;
            if (serve_now) begin
                chunk_valid  <= 1'b1;
                chunk_type   <= serve_type;
                chunk        <= read_word(serve_type, serve_idx);
                served_count <= served_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (chunk_request) begin
                        cap_type <= request_type;
                        cap_idx  <= chunk_index;
                        busy     <= 1'b1;
                        if (!req_legal) begin
                            err   <= 1'b1;
                            state <= COOL;
                        end else if (RESP_DELAY == 0) begin
                            state <= COOL;
                        end else begin
                            dly   <= DLY;
                            state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    dly <= dly - 4'd1;
                    if (dly == 4'd1) state <= COOL;
                end
                COOL: begin
                    if (!chunk_request) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
